int2float_pipe: RTL

INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

---
 rtl/int2float_pipe_pkg.sv | 19 +
 rtl/int2float_pipe_if.sv | 31 +++
 rtl/lzc_param.sv | 26 ++
 rtl/int2float_pipe.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/int2float_pipe_pkg.sv
// int2float_pipe_pkg
//   Shared FP32 constants and the packed single-precision layout used by the
//   integer-to-float pipeline.
package int2float_pipe_pkg;

    localparam int unsigned FpW     = 32;   // total encoding width
    localparam int unsigned FpExpW  = 8;    // exponent field width
    localparam int unsigned FpManW  = 23;   // mantissa field width
    localparam int unsigned FpBias  = 127;  // exponent bias

    localparam logic [FpW-1:0] FpZero = 32'h0000_0000;  // +0.0

    typedef struct packed {
        logic              sign;
        logic [FpExpW-1:0] exp;
        logic [FpManW-1:0] man;
    } fp32_t;

endpackage

// File: rtl/int2float_pipe_if.sv
// int2float_pipe_if
//   Valid/ready streaming bundle for the integer-to-float converter.
//   Input side : in_valid, in_ready, in_data[INT_W]
//   Output side: out_valid, out_ready, out_data[32], out_inexact
//   slave  : the converter (consumes in_*, produces out_*)
//   master : the environment driving samples and accepting results
interface int2float_pipe_if
    import int2float_pipe_pkg::*;
#(
    parameter int unsigned INT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [FpW-1:0]   out_data;
    logic             out_inexact;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

endinterface

// File: rtl/lzc_param.sv
// lzc_param
//   Leading-one detector over a WIDTH-bit vector.
//   in_i   : vector to scan
//   pos_o  : index of the most significant set bit (0 when in_i is zero)
//   zero_o : in_i has no set bit
module lzc_param #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned PosW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [PosW-1:0]  pos_o,
    output logic             zero_o
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        pos_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                pos_o = PosW'(i);
            end
        end
        zero_o = ~|in_i;
    end

endmodule

// File: rtl/int2float_pipe.sv
// int2float_pipe
//   Three-stage integer to IEEE-754 single-precision converter with
//   valid/ready flow control and round-to-nearest-even.
//     S1: sign extract and magnitude
//     S2: leading-one detect and left-normalise
//     S3: round, pack, output register
//   Ports:
//     clk   : sole clock, rising edge
//     reset : synchronous, active-high; drops all samples in flight
//     bus   : int2float_pipe_if slave (in_* sample stream, out_* result stream)
//   Parameters:
//     INT_W  : input width, 2..32
//     SIGNED : 1 = two's-complement input, 0 = unsigned input
module int2float_pipe
    import int2float_pipe_pkg::*;
#(
    parameter int unsigned INT_W  = 16,
    parameter bit          SIGNED = 1'b1
) (
    input logic             clk,
    input logic             reset,
    int2float_pipe_if.slave bus
);

    localparam int unsigned PosW     = $clog2(INT_W);
    localparam int unsigned NormW    = 32;                  // normalised width, leading one at MSB
    localparam int unsigned FracW    = NormW - 1;           // bits below the leading one
    localparam int unsigned GuardBit = FracW - FpManW - 1;  // first bit dropped by the mantissa

    // Flow control: each stage may load when it is empty or its content leaves.
    logic s1_ready, s2_ready, s3_ready;

    // Stage 1 state
    logic             s1_valid_q;
    logic             s1_sign_q, s1_sign_d;
    logic [INT_W-1:0] s1_mag_q, s1_mag_d;

    // Stage 2 state
    logic             s2_valid_q;
    logic             s2_sign_q;
    logic             s2_zero_q;
    logic [4:0]       s2_pos_q, s2_pos_d;
    logic [FracW-1:0] s2_frac_q, s2_frac_d;

    // Stage 3 (output register)
    logic             s3_valid_q;
    logic [FpW-1:0]   s3_data_q, s3_data_d;
    logic             s3_inexact_q, s3_inexact_d;

    // Leading-one detector results on the S1 magnitude
    logic [PosW-1:0]  lz_pos;
    logic             lz_zero;

    // Rounding intermediates
    logic [FpManW-1:0] man_trunc;
    logic              guard, sticky, round_up;
    logic [FpManW:0]   man_rnd;
    logic [FpExpW-1:0] exp_fld;
    fp32_t             res;

    assign s3_ready = !s3_valid_q || bus.out_ready;
    assign s2_ready = !s2_valid_q || s3_ready;
    assign s1_ready = !s1_valid_q || s2_ready;

    assign bus.in_ready    = s1_ready && !reset;
    assign bus.out_valid   = s3_valid_q;
    assign bus.out_data    = s3_data_q;
    assign bus.out_inexact = s3_inexact_q;

    // S1: the negation is done on INT_W bits, so the most negative input
    // yields 2^(INT_W-1) as an unsigned magnitude without overflow.
    always_comb begin
        s1_sign_d = SIGNED && bus.in_data[INT_W-1];
        s1_mag_d  = bus.in_data;
        if (s1_sign_d) begin
            s1_mag_d = ~bus.in_data + INT_W'(1);
        end
    end

    lzc_param #(
        .WIDTH (INT_W)
    ) u_lzc (
        .in_i   (s1_mag_q),
        .pos_o  (lz_pos),
        .zero_o (lz_zero)
    );

    // S2: shift the leading one up to bit NormW-1 and keep only what lies below it.
    always_comb begin
        s2_pos_d  = 5'(lz_pos);
        s2_frac_d = FracW'(NormW'(s1_mag_q) << (5'(NormW - 1) - s2_pos_d));
    end

    // S3: bits below the guard form the sticky; they are all zero when p <= 23,
    // so rounding and inexact fall out naturally for small magnitudes.
    always_comb begin
        man_trunc = s2_frac_q[FracW-1 -: FpManW];
        guard     = s2_frac_q[GuardBit];
        sticky    = |s2_frac_q[GuardBit-1:0];
        round_up  = guard && (sticky || man_trunc[0]);
        man_rnd   = {1'b0, man_trunc} + {{FpManW{1'b0}}, round_up};
        // A carry out of the mantissa leaves man_rnd[FpManW-1:0] == 0 already.
        exp_fld   = FpExpW'(FpBias) + FpExpW'(s2_pos_q) + FpExpW'(man_rnd[FpManW]);

        res.sign  = s2_sign_q;
        res.exp   = exp_fld;
        res.man   = man_rnd[FpManW-1:0];

        s3_data_d    = res;
        s3_inexact_d = guard || sticky;
        if (s2_zero_q) begin
            s3_data_d    = FpZero;
            s3_inexact_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_mag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_pos_q     <= '0;
            s2_frac_q    <= '0;
            s3_valid_q   <= 1'b0;
            s3_data_q    <= FpZero;
            s3_inexact_q <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q <= s1_sign_d;
                    s1_mag_q  <= s1_mag_d;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q <= s1_sign_q;
                    s2_zero_q <= lz_zero;
                    s2_pos_q  <= s2_pos_d;
                    s2_frac_q <= s2_frac_d;
                end
            end
            if (s3_ready) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    s3_data_q    <= s3_data_d;
                    s3_inexact_q <= s3_inexact_d;
                end
            end
        end
    end

endmodule
